// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC pipeline: control-bit positions,
// MEM-stage FSM states and default datapath widths.
package riscv_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned REG_SIZE  = 5;

    // mem_control_signals bit positions
    localparam int unsigned MEM_READ_BIT  = 1;
    localparam int unsigned MEM_WRITE_BIT = 0;

    // wb_control_signals bit positions
    localparam int unsigned REG_WRITE_BIT  = 1;
    localparam int unsigned MEM_TO_REG_BIT = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the presented fields or a bubble.
module mem_wb_reg #(
    parameter int unsigned W = 32,
    parameter int unsigned R = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [1:0]   i_wb,
    input  logic [W-1:0] i_rdata,
    input  logic [W-1:0] i_alu,
    input  logic [R-1:0] i_dest,
    output logic         o_valid,
    output logic [1:0]   o_wb,
    output logic [W-1:0] o_rdata,
    output logic [W-1:0] o_alu,
    output logic [R-1:0] o_dest
);

    // Capture a real instruction when loaded; otherwise insert an all-zero bubble
    always_ff @(posedge clk) begin
        if (!rst_n || !i_load) begin
            o_valid <= 1'b0;
            o_wb    <= '0;
            o_rdata <= '0;
            o_alu   <= '0;
            o_dest  <= '0;
        end else begin
            o_valid <= 1'b1;
            o_wb    <= i_wb;
            o_rdata <= i_rdata;
            o_alu   <= i_alu;
            o_dest  <= i_dest;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack handshake with pipeline stall, alignment
// check, and the MEM/WB register feeding write-back.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned word_size = WORD_SIZE,
    parameter int unsigned reg_size  = REG_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           mem_control_signals,
    input  logic [1:0]           wb_control_in,
    input  logic [word_size-1:0] alu_result_in,
    input  logic [word_size-1:0] store_data_in,
    input  logic [reg_size-1:0]  dest_reg_in,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [word_size-1:0] dmem_addr,
    output logic [word_size-1:0] dmem_wdata,
    input  logic [word_size-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 align_err,
    output logic                 out_valid,
    output logic [1:0]           wb_control_signals,
    output logic [word_size-1:0] ReadData,
    output logic [word_size-1:0] AluResult,
    output logic [reg_size-1:0]  destination_reg
);

    mem_state_t           r_state;
    mem_state_t           w_next;
    logic [word_size-1:0] r_addr;
    logic [word_size-1:0] r_wdata;
    logic                 r_we;
    logic [1:0]           r_wb;
    logic [reg_size-1:0]  r_dest;
    logic                 r_align_err;

    logic                 w_memop;
    logic                 w_aligned;
    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_load;
    logic [1:0]           w_wb;
    logic [word_size-1:0] w_rdata;
    logic [word_size-1:0] w_alu;
    logic [reg_size-1:0]  w_dest;

    assign w_memop   = mem_control_signals[MEM_READ_BIT] | mem_control_signals[MEM_WRITE_BIT];
    assign w_aligned = (alu_result_in[1:0] == 2'b00);

    // Next-state and MEM/WB load selection; ack is only honoured in ACCESS
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_misalign = 1'b0;
        w_load     = 1'b0;
        w_wb       = wb_control_in;
        w_rdata    = '0;
        w_alu      = alu_result_in;
        w_dest     = dest_reg_in;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!w_memop) begin
                        w_load = 1'b1;
                    end else if (w_aligned) begin
                        w_accept = 1'b1;
                        w_next   = ST_ACCESS;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    w_load  = 1'b1;
                    w_wb    = r_wb;
                    w_rdata = r_we ? '0 : dmem_rdata;
                    w_alu   = r_addr;
                    w_dest  = r_dest;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, access latches and the one-cycle alignment error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_wb        <= '0;
            r_dest      <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_align_err <= w_misalign;
            if (w_accept) begin
                r_addr  <= alu_result_in;
                r_wdata <= store_data_in;
                // Both bits set is treated as a read
                r_we    <= mem_control_signals[MEM_WRITE_BIT] & ~mem_control_signals[MEM_READ_BIT];
                r_wb    <= wb_control_in;
                r_dest  <= dest_reg_in;
            end
        end
    end

    assign stall      = ((r_state == ST_IDLE) & in_valid & w_memop & w_aligned)
                      | ((r_state == ST_ACCESS) & ~dmem_ack);
    assign dmem_req   = (r_state == ST_ACCESS);
    assign dmem_we    = dmem_req & r_we;
    assign dmem_addr  = dmem_req ? r_addr  : '0;
    assign dmem_wdata = dmem_req ? r_wdata : '0;
    assign align_err  = r_align_err;

    mem_wb_reg #(
        .W (word_size),
        .R (reg_size)
    ) u_mem_wb_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_wb    (w_wb),
        .i_rdata (w_rdata),
        .i_alu   (w_alu),
        .i_dest  (w_dest),
        .o_valid (out_valid),
        .o_wb    (wb_control_signals),
        .o_rdata (ReadData),
        .o_alu   (AluResult),
        .o_dest  (destination_reg)
    );

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage plus MEM/WB pipeline register of the 5-stage RISC pipeline. It sits directly upstream of the write-back stage and produces that stage's `wb_control_signals`, `ReadData`, `AluResult` and `destination_reg` inputs. Loads and stores go to data memory over a req/ack handshake, and the stage stalls the pipeline until the access completes. Non-memory instructions pass through in one cycle.

## Interface
- `word_size`, 32: data/address width
- `reg_size`, 5: register-index width

Clock is `clk`; reset is `rst_n`, synchronous and active-low. Ports:
- `clk`  in  1  pipeline clock
- `rst_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  EX/MEM holds a valid instruction
- `mem_control_signals`  in  2  bit1 MemRead, bit0 MemWrite (both set is illegal; treated as read)
- `wb_control_in`  in  2  bit1 RegWrite, bit0 MemtoReg; forwarded unchanged
- `alu_result_in`  in  word_size  ALU result, also the memory address
- `store_data_in`  in  word_size  store data
- `dest_reg_in`  in  reg_size  destination register
- `stall`  out  1  upstream must hold EX/MEM inputs stable
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  word_size  word-aligned address
- `dmem_wdata`  out  word_size  store data
- `dmem_rdata`  in  word_size  load data, valid with ack
- `dmem_ack`  in  1  access complete
- `align_err`  out  1  one-cycle pulse: misaligned access squashed
- `out_valid`  out  1  MEM/WB register holds a real instruction
- `wb_control_signals`  out  2  to WB stage
- `ReadData`  out  word_size  to WB stage
- `AluResult`  out  word_size  to WB stage
- `destination_reg`  out  reg_size  to WB stage

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, no mem op (`in_valid` with no MemRead/MemWrite):
  - MEM/WB register loads the inputs on the next edge.
  - `ReadData` is cleared to 0.
- IDLE, `in_valid` with a memory op and `alu_result_in[1:0]==0`:
  - Latch address, store data, op type and the WB fields.
  - Go to ACCESS.
  - MEM/WB loads a bubble (`out_valid`=0, `wb_control_signals`=0).
- IDLE, memory op with misaligned address:
  - No request is issued.
  - `align_err` pulses next cycle.
  - MEM/WB loads a bubble; no stall.
- ACCESS:
  - `dmem_req`=1, and `dmem_we`/`dmem_addr`/`dmem_wdata` come from the latched values, stable until ack.
  - On `dmem_ack`, MEM/WB loads the latched fields, with `ReadData`=`dmem_rdata` for loads and 0 for stores. `out_valid`=1. Go to IDLE.
  - Without ack, stay in ACCESS and load a bubble.
- `stall` = (IDLE & `in_valid` & memop & aligned) | (ACCESS & !`dmem_ack`). It is combinational.
- Stores keep `wb_control_in` as given (normally RegWrite=0).
- `dmem_ack` in IDLE is ignored.
- `!in_valid` loads a bubble.

## Timing
- Reset values: state IDLE; `stall`, `dmem_req`, `dmem_we`, `align_err` and `out_valid` = 0; all data outputs 0.
- Non-memory op: result visible on MEM/WB outputs 1 cycle after acceptance.
- Memory op accepted at edge T:
  - `dmem_req` is high from T+1.
  - If ack arrives in the cycle starting at T+k (k≥1), outputs are updated at edge T+k+1, and `stall` is low during that cycle.
  - Zero-wait memory (ack combinational with req) gives a 2-cycle load, with stall for 1 cycle.
- A new instruction is accepted in the same cycle that ack drops `stall`.
- Reset asserted mid-ACCESS:
  - Next edge returns to IDLE with `dmem_req`=0 and outputs cleared.
  - A late ack is ignored.
- Back-to-back memory ops: the second is accepted in IDLE the edge after the first completes.

## Structure
- Shared package `riscv_pkg`: indices of the MemRead/MemWrite/RegWrite/MemtoReg bits, FSM state encoding, and the `word_size`/`reg_size` defaults.
- Sub-module `mem_wb_reg`: pipeline register with load/bubble control and synchronous active-low reset. The FSM and handshake logic stay in the top level.

## Test plan
- ALU op (`wb_control_in`=2'b10, `alu_result_in`=32'h14, `dest_reg_in`=5'h02) -> next cycle `AluResult`=32'h14, `destination_reg`=5'h02, `wb_control_signals`=2'b10, `ReadData`=0, no stall.
- Load from 32'h40 with ack after 3 cycles and `dmem_rdata`=32'h16 -> `stall` high 3 cycles, `dmem_addr`=32'h40 stable, then `ReadData`=32'h16, `wb_control_signals`=2'b11, `out_valid`=1.
- Store 32'hDEAD to 32'h80 with ack at k=1 -> `dmem_we`=1, `dmem_wdata`=32'hDEAD for one cycle; MEM/WB shows the store with `ReadData`=0.
- Load at misaligned 32'h42 -> `dmem_req` never rises, `align_err` pulses 1 cycle, `out_valid`=0, no stall.
- Reset asserted in ACCESS before ack, then ack pulse -> `dmem_req`=0 next cycle, all outputs 0, ack has no effect.
- Load then ALU op back-to-back with ack at k=2 -> ALU op is held during the stall and appears exactly 1 cycle after the load result.
